alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Initiator side of the ALU operand/selector interface. Accepts an operation request (ALUOP/FUNCT plus two operands) over a valid/ready handshake and decodes it to a 4-bit SELECTOR. It then drives the combinational ALU with stable inputs for a per-operation latency, captures RESULTADO/ZF, and returns the result over a second valid/ready handshake. Sits between the control unit / register-read stage and the ALU datapath, allowing multi-cycle timing for MUL/DIV paths.

Parameters:
LAT_BASE, 1, cycles from accept to OUT_VALID for add/sub/logic/slt/illegal/div-by-zero (≥1)
LAT_MUL, 2, cycles from accept to OUT_VALID for multiply (≥1)
LAT_DIV, 4, cycles from accept to OUT_VALID for divide (≥1, ≤255)

Ports:
CLK  in  1  single clock, rising edge
RST  in  1  asynchronous, active-high reset
IN_VALID  in  1  request valid
IN_READY  out  1  request accepted when IN_VALID&IN_READY at CLK edge
ALUOP  in  2  00 add, 01 sub, 10 use FUNCT, 11 illegal
FUNCT  in  6  R-type function code
OP_A  in  32  operand A
OP_B  in  32  operand B
A_ALUC  out  32  to ALU operand A (registered)
B_ALUC  out  32  to ALU operand B (registered)
SELECTOR  out  4  to ALU op select (registered)
RESULTADO  in  32  from ALU
ZF  in  1  from ALU zero flag
OUT_VALID  out  1  result valid
OUT_READY  in  1  result consumed when OUT_VALID&OUT_READY at CLK edge
RES  out  32  captured result
RES_ZF  out  1  captured zero flag
ERR  out  1  illegal op or divide-by-zero for this result

Behaviour:
- Selector codes: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 and, 0101 or, 0110 xor, 0111 nor, 1000 slt, 1111 none (ALU returns 0).
- Decode: ALUOP 00→0000, 01→0001, 11→illegal. ALUOP 10 uses FUNCT: 100000→0000, 100010→0001, 011000→0010, 011010→0011, 100100→0100, 100101→0101, 100110→0110, 100111→0111, 101010→1000, any other FUNCT→illegal.
- FSM states IDLE, WAIT, DONE. IN_READY=1 only in IDLE; OUT_VALID=1 only in DONE. No overlap of requests.
- IDLE, on accept edge E0:
  - Register OP_A→A_ALUC and OP_B→B_ALUC.
  - Load decoded selector into SELECTOR. Illegal or div-by-zero (sel 0011 with OP_B==0) loads 1111.
  - Load counter with L−1, where L = LAT_MUL for 0010, LAT_DIV for 0011 with B≠0, otherwise LAT_BASE. Go to WAIT.
- WAIT: A_ALUC, B_ALUC and SELECTOR remain stable. Counter decrements each edge. On the edge where the counter is 0:
  - Capture RES/RES_ZF/ERR and go to DONE.
  - OUT_VALID rises exactly L edges after E0.
- Capture values:
  - Normal op: RES=RESULTADO, RES_ZF=ZF, ERR=0.
  - Illegal op: RES=0, RES_ZF=1, ERR=1.
  - Div-by-zero: RES=32'hFFFFFFFF, RES_ZF=0, ERR=1.
- DONE: RES, RES_ZF, ERR and OUT_VALID are held until OUT_READY=1. On that edge go to IDLE; OUT_VALID drops and IN_READY rises. IN_VALID during WAIT/DONE is ignored; the upstream holds it.
- A_ALUC/B_ALUC/SELECTOR hold their last values in IDLE and DONE.
- Reset (asynchronous, any state, including mid-WAIT): state IDLE, counter 0, all outputs 0 (SELECTOR=0000). Any in-flight operation is discarded with no OUT_VALID. IN_READY=1 from the first edge after release.
- Counter width: 8 bits.

Decomposition:
- Shared package alu_pkg holds:
  - selector constants (SEL_ADD…SEL_SLT, SEL_NONE);
  - ALUOP codes and FUNCT codes;
  - FSM state typedef.
- One combinational sub-module, alu_decode (ALUOP, FUNCT → SELECTOR, illegal), reused by the control unit.
- Counter and FSM stay in alu_issue_ctrl.

Test Plan:
- ALUOP=10, FUNCT=100000, A=5, B=7, ALU model attached → SELECTOR=0000 after E0; OUT_VALID 1 edge later; RES=12, RES_ZF=0, ERR=0.
- ALUOP=01, A=B=32'h1234 → SELECTOR=0001, RES=0, RES_ZF=1, ERR=0 after 1 edge.
- FUNCT=011010, A=100, B=7 → OUT_VALID exactly 4 edges after accept; RES=14; A_ALUC/B_ALUC/SELECTOR constant throughout WAIT.
- FUNCT=011010, A=9, B=0 → SELECTOR=1111, RES=FFFFFFFF, ERR=1 after 1 edge. FUNCT=000000 → RES=0, RES_ZF=1, ERR=1.
- OUT_READY=0 for 5 cycles after OUT_VALID → RES/OUT_VALID held, IN_READY=0, a new IN_VALID request is not accepted. OUT_READY=1 → IDLE next edge, then the new request is accepted.
- Start DIV, assert RST in the 2nd WAIT cycle → all outputs 0 immediately; no OUT_VALID after release; IN_READY=1 after the first post-reset edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU interface definitions: selector codes, ALUOP/FUNCT encodings
// and the issue-controller FSM state type.
package alu_pkg;

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b0001;
  localparam logic [3:0] SEL_MUL  = 4'b0010;
  localparam logic [3:0] SEL_DIV  = 4'b0011;
  localparam logic [3:0] SEL_AND  = 4'b0100;
  localparam logic [3:0] SEL_OR   = 4'b0101;
  localparam logic [3:0] SEL_XOR  = 4'b0110;
  localparam logic [3:0] SEL_NOR  = 4'b0111;
  localparam logic [3:0] SEL_SLT  = 4'b1000;
  localparam logic [3:0] SEL_NONE = 4'b1111;

  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_SUB     = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
  localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;
  localparam logic [5:0] FUNCT_DIV = 6'b011010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational ALUOP/FUNCT decoder producing the ALU selector and an
// illegal-operation flag.
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] sel,
  output logic       illegal
);

  // Map request encoding to selector; anything unlisted is illegal
  always_comb begin
    sel     = SEL_NONE;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: sel = SEL_ADD;
      ALUOP_SUB: sel = SEL_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: sel = SEL_ADD;
          FUNCT_SUB: sel = SEL_SUB;
          FUNCT_MUL: sel = SEL_MUL;
          FUNCT_DIV: sel = SEL_DIV;
          FUNCT_AND: sel = SEL_AND;
          FUNCT_OR:  sel = SEL_OR;
          FUNCT_XOR: sel = SEL_XOR;
          FUNCT_NOR: sel = SEL_NOR;
          FUNCT_SLT: sel = SEL_SLT;
          default: begin
            sel     = SEL_NONE;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        sel     = SEL_NONE;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: accepts a request, holds the
// ALU inputs stable for a per-op latency, then returns the captured result.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int LAT_BASE = 1,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [1:0]  ALUOP,
  input  logic [5:0]  FUNCT,
  input  logic [31:0] OP_A,
  input  logic [31:0] OP_B,
  output logic [31:0] A_ALUC,
  output logic [31:0] B_ALUC,
  output logic [3:0]  SELECTOR,
  input  logic [31:0] RESULTADO,
  input  logic        ZF,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] RES,
  output logic        RES_ZF,
  output logic        ERR
);

  state_e      state_r, state_nxt_s;
  logic [7:0]  cnt_r;
  logic [31:0] a_r, b_r, res_r;
  logic [3:0]  sel_r, dec_sel_s, load_sel_s;
  logic        dec_illegal_s, div0_s, accept_s;
  logic        illegal_r, div0_r, res_zf_r, err_r, in_ready_r, out_valid_r;
  logic [7:0]  lat_s;

  alu_decode u_decode (
    .aluop   (ALUOP),
    .funct   (FUNCT),
    .sel     (dec_sel_s),
    .illegal (dec_illegal_s)
  );

  // in_ready_r is only ever set while the FSM sits in IDLE
  assign accept_s = IN_VALID & in_ready_r;
  assign div0_s   = (~dec_illegal_s) & (dec_sel_s == SEL_DIV) & (OP_B == 32'd0);

  // Selector and latency reload value for the request being accepted
  always_comb begin
    load_sel_s = dec_sel_s;
    lat_s      = 8'(LAT_BASE - 1);
    if (dec_illegal_s || div0_s) begin
      load_sel_s = SEL_NONE;
    end else begin
      load_sel_s = dec_sel_s;
    end
    if (load_sel_s == SEL_MUL) begin
      lat_s = 8'(LAT_MUL - 1);
    end else if (load_sel_s == SEL_DIV) begin
      lat_s = 8'(LAT_DIV - 1);
    end else begin
      lat_s = 8'(LAT_BASE - 1);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_WAIT;
        else          state_nxt_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (cnt_r == 8'd0) state_nxt_s = ST_DONE;
        else               state_nxt_s = ST_WAIT;
      end
      ST_DONE: begin
        if (OUT_READY) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, handshake flags, ALU drive registers, latency counter and result capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      sel_r       <= 4'b0000;
      illegal_r   <= 1'b0;
      div0_r      <= 1'b0;
      res_r       <= 32'd0;
      res_zf_r    <= 1'b0;
      err_r       <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r       <= OP_A;
            b_r       <= OP_B;
            sel_r     <= load_sel_s;
            cnt_r     <= lat_s;
            illegal_r <= dec_illegal_s;
            div0_r    <= div0_s;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 8'd0) begin
            if (illegal_r) begin
              res_r    <= 32'd0;
              res_zf_r <= 1'b1;
              err_r    <= 1'b1;
            end else if (div0_r) begin
              res_r    <= 32'hFFFF_FFFF;
              res_zf_r <= 1'b0;
              err_r    <= 1'b1;
            end else begin
              res_r    <= RESULTADO;
              res_zf_r <= ZF;
              err_r    <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        ST_DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= 8'd0;
        end
      endcase
    end
  end

  assign IN_READY  = in_ready_r;
  assign OUT_VALID = out_valid_r;
  assign A_ALUC    = a_r;
  assign B_ALUC    = b_r;
  assign SELECTOR  = sel_r;
  assign RES       = res_r;
  assign RES_ZF    = res_zf_r;
  assign ERR       = err_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases plus randomized
// requests compared against a behavioural model of the request semantics.
module tb_alu_issue_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [1:0]  ALUOP = 2'b00;
  logic [5:0]  FUNCT = 6'b000000;
  logic [31:0] OP_A = 32'd0;
  logic [31:0] OP_B = 32'd0;
  logic [31:0] A_ALUC, B_ALUC;
  logic [3:0]  SELECTOR;
  logic [31:0] RESULTADO;
  logic        ZF;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] RES;
  logic        RES_ZF;
  logic        ERR;

  int n_tests = 0;
  int n_fail  = 0;

  alu_issue_ctrl #(.LAT_BASE(1), .LAT_MUL(2), .LAT_DIV(4)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ALUOP(ALUOP), .FUNCT(FUNCT), .OP_A(OP_A), .OP_B(OP_B),
    .A_ALUC(A_ALUC), .B_ALUC(B_ALUC), .SELECTOR(SELECTOR),
    .RESULTADO(RESULTADO), .ZF(ZF), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RES(RES), .RES_ZF(RES_ZF), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Combinational ALU attached to the controller outputs
  always_comb begin
    case (SELECTOR)
      4'b0000: RESULTADO = A_ALUC + B_ALUC;
      4'b0001: RESULTADO = A_ALUC - B_ALUC;
      4'b0010: RESULTADO = A_ALUC * B_ALUC;
      4'b0011: RESULTADO = (B_ALUC == 32'd0) ? 32'd0 : A_ALUC / B_ALUC;
      4'b0100: RESULTADO = A_ALUC & B_ALUC;
      4'b0101: RESULTADO = A_ALUC | B_ALUC;
      4'b0110: RESULTADO = A_ALUC ^ B_ALUC;
      4'b0111: RESULTADO = ~(A_ALUC | B_ALUC);
      4'b1000: RESULTADO = ($signed(A_ALUC) < $signed(B_ALUC)) ? 32'd1 : 32'd0;
      default: RESULTADO = 32'd0;
    endcase
    ZF = (RESULTADO == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // What a request should produce, straight from the operation semantics
  task automatic ref_model(input logic [1:0] op, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [3:0] e_sel, output logic [31:0] e_res,
                           output logic e_zf, output logic e_err, output int e_lat);
    string kind;
    if (op == 2'b00) kind = "add";
    else if (op == 2'b01) kind = "sub";
    else if (op == 2'b11) kind = "bad";
    else begin
      case (fn)
        6'b100000: kind = "add";
        6'b100010: kind = "sub";
        6'b011000: kind = "mul";
        6'b011010: kind = "div";
        6'b100100: kind = "and";
        6'b100101: kind = "or";
        6'b100110: kind = "xor";
        6'b100111: kind = "nor";
        6'b101010: kind = "slt";
        default:   kind = "bad";
      endcase
    end
    if (kind == "div" && b == 32'd0) kind = "dz";
    e_err = 1'b0;
    e_lat = 1;
    case (kind)
      "add": begin e_sel = 4'b0000; e_res = a + b; end
      "sub": begin e_sel = 4'b0001; e_res = a - b; end
      "mul": begin e_sel = 4'b0010; e_res = a * b; e_lat = 2; end
      "div": begin e_sel = 4'b0011; e_res = a / b; e_lat = 4; end
      "and": begin e_sel = 4'b0100; e_res = a & b; end
      "or":  begin e_sel = 4'b0101; e_res = a | b; end
      "xor": begin e_sel = 4'b0110; e_res = a ^ b; end
      "nor": begin e_sel = 4'b0111; e_res = ~(a | b); end
      "slt": begin e_sel = 4'b1000; e_res = {31'd0, $signed(a) < $signed(b)}; end
      "dz":  begin e_sel = 4'b1111; e_res = 32'hFFFF_FFFF; e_err = 1'b1; end
      default: begin e_sel = 4'b1111; e_res = 32'd0; e_err = 1'b1; end
    endcase
    e_zf = (kind == "dz") ? 1'b0 : (e_res == 32'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [3:0]  e_sel;
    logic [31:0] e_res;
    logic        e_zf, e_err;
    int          e_lat, lat, waitc;
    ref_model(op, fn, a, b, e_sel, e_res, e_zf, e_err, e_lat);
    waitc = 0;
    while (!IN_READY && waitc < 20) begin
      @(posedge CLK); #1; waitc++;
    end
    check("in_ready_idle", {31'd0, IN_READY}, 32'd1);
    ALUOP = op; FUNCT = fn; OP_A = a; OP_B = b; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0; OP_A = ~a; OP_B = ~b;
    check("sel", {28'd0, SELECTOR}, {28'd0, e_sel});
    check("a_aluc", A_ALUC, a);
    check("b_aluc", B_ALUC, b);
    check("in_ready_busy", {31'd0, IN_READY}, 32'd0);
    lat = 0;
    while (!OUT_VALID && lat < 300) begin
      check("wait_sel", {28'd0, SELECTOR}, {28'd0, e_sel});
      check("wait_a", A_ALUC, a);
      @(posedge CLK); #1; lat++;
    end
    check("latency", lat, e_lat);
    check("res", RES, e_res);
    check("res_zf", {31'd0, RES_ZF}, {31'd0, e_zf});
    check("err", {31'd0, ERR}, {31'd0, e_err});
    for (int i = 0; i < hold; i++) begin
      IN_VALID = 1'b1; OP_A = a ^ 32'h5A5A_5A5A;
      @(posedge CLK); #1;
      check("hold_valid", {31'd0, OUT_VALID}, 32'd1);
      check("hold_res", RES, e_res);
      check("hold_in_ready", {31'd0, IN_READY}, 32'd0);
      check("hold_a_aluc", A_ALUC, a);
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    check("drop_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rise_ready", {31'd0, IN_READY}, 32'd1);
  endtask

  logic [5:0] fpool [10] = '{6'b100000, 6'b100010, 6'b011000, 6'b011010, 6'b100100,
                             6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b000000};

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", {31'd0, IN_READY}, 32'd0);
    check("rst_sel", {28'd0, SELECTOR}, 32'd0);
    check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    #10 RST = 1'b0;
    @(posedge CLK); #1;
    check("ready_after_rst", {31'd0, IN_READY}, 32'd1);

    // Directed cases
    run_op(2'b10, 6'b100000, 32'd5, 32'd7, 0);
    run_op(2'b01, 6'b000000, 32'h1234, 32'h1234, 0);
    run_op(2'b10, 6'b011010, 32'd100, 32'd7, 1);
    run_op(2'b10, 6'b011010, 32'd9, 32'd0, 0);
    run_op(2'b10, 6'b000000, 32'd3, 32'd4, 0);
    run_op(2'b11, 6'b100000, 32'd3, 32'd4, 0);
    run_op(2'b10, 6'b011000, 32'd6, 32'd7, 5);
    run_op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 0);

    // Randomized requests
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic [5:0]  fn;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fpool[$urandom_range(0, 9)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom_range(0, 1) == 1 ? a : $urandom);
      run_op(op, fn, a, b, $urandom_range(0, 3));
    end

    // Reset during WAIT of a divide
    ALUOP = 2'b10; FUNCT = 6'b011010; OP_A = 32'd100; OP_B = 32'd7; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    check("mid_rst_a", A_ALUC, 32'd0);
    check("mid_rst_b", B_ALUC, 32'd0);
    check("mid_rst_sel", {28'd0, SELECTOR}, 32'd0);
    check("mid_rst_in_ready", {31'd0, IN_READY}, 32'd0);
    check("mid_rst_res", {RES[30:0], RES_ZF | ERR | OUT_VALID}, 32'd0);
    #6 RST = 1'b0;
    @(posedge CLK); #1;
    check("post_rst_ready", {31'd0, IN_READY}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      check("post_rst_no_valid", {31'd0, OUT_VALID}, 32'd0);
    end
    run_op(2'b00, 6'b000000, 32'd1, 32'd2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
